// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer for the EX stage.
// Borrows the shared ALU for WIDTH cycles and leaves the result in HI/LO.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctl,
  output logic             alu_own,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             op_q, op_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
    end
  end

  assign sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    dbz_d   = dbz_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          opnd_d = opb;
          cnt_d  = '0;
          dbz_d  = 1'b0;
          hi_d   = '0;
          lo_d   = opa;
          if (op && (opb == '0)) begin
            state_d = FIN;
            dbz_d   = 1'b1;
            hi_d    = opa;
            lo_d    = '1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIN;
        if (!op_q) begin
          // shift-add: carry out becomes the top product bit
          alu_ctl = 3'b010;
          alu_a   = hi_q;
          alu_b   = lo_q[0] ? opnd_q : '0;
          hi_d    = {alu_cout, alu_result[WIDTH-1:1]};
          lo_d    = {alu_result[0], lo_q[WIDTH-1:1]};
        end else begin
          // restoring divide: a set hi MSB means sh exceeds any divisor
          alu_ctl = 3'b110;
          alu_a   = sh;
          alu_b   = opnd_q;
          if (hi_q[WIDTH-1] || alu_cout) begin
            hi_d = alu_result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = sh;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign alu_own     = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural shared ALU
// and a plain-arithmetic reference model for MULTU/DIVU.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic [31:0] alu_a, alu_b, hi, lo;
  logic [2:0]  alu_ctl;
  logic        alu_own, busy, done, div_by_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          n;
    int          last;
  } exp_t;

  exp_t exp_q[$];

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_own(alu_own), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared MIPS ALU; SUB carry is the not-borrow flag
  always_comb begin
    logic [32:0] s;
    s = '0;
    alu_result = '0;
    alu_cout = 1'b0;
    case (alu_ctl)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = s[31:0];
        alu_cout = s[32];
      end
      3'b110: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = s[31:0];
        alu_cout = s[32];
      end
      3'b111: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: timing of busy/alu_own/done and result check on done
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        logic eb, eo, ed;
        int k;
        eb = 1'b0; eo = 1'b0; ed = 1'b0;
        if (exp_q.size() > 0) begin
          k = cyc - exp_q[0].n;
          eb = (k >= 1) && (k <= exp_q[0].last);
          eo = !exp_q[0].dbz && (k >= 1) && (k <= 32);
          ed = (k == exp_q[0].last);
        end
        chk("busy", {63'd0, busy}, {63'd0, eb});
        chk("alu_own", {63'd0, alu_own}, {63'd0, eo});
        chk("done", {63'd0, done}, {63'd0, ed});
        if (!alu_own)
          chk("alu_idle_bus", {alu_a, alu_b[28:0], alu_ctl}, 64'd0);
        if (done && exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hi", {32'd0, hi}, {32'd0, e.hi});
          chk("lo", {32'd0, lo}, {32'd0, e.lo});
          chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        end
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("issue_timeout", 64'd1, 64'd0);
    start = 1'b1;
    op = o;
    opa = a;
    opb = b;
    e.n = cyc;
    e.last = 33;
    e.dbz = 1'b0;
    if (o && b == 0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
      e.last = 1;
    end else if (o) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      p = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom);
    opa = $urandom;
    opb = $urandom;
  endtask

  initial begin
    int t;
    logic [31:0] b;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_ctl", {57'd0, busy, done, div_by_zero, alu_own, alu_ctl},
        64'd0);
    chk("rst_bus", {alu_a, alu_b}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd7, 32'd6);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b1, 32'd100, 32'd7);
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    issue(1'b1, 32'd5, 32'd0);
    issue(1'b1, 32'd9, 32'd3);

    // starts in cycle 5 and in the done cycle must be ignored
    issue(1'b0, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; opa = $urandom; opb = 32'd0;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("done_timeout", 64'd1, 64'd0);
    start = 1'b1; op = 1'b0; opa = $urandom; opb = $urandom;
    @(negedge clk);
    start = 1'b0;
    issue(1'b0, 32'd11, 32'd13);

    // reset in cycle 10 of a divide discards it
    issue(1'b1, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    issue(1'b0, 32'd2, 32'd3);

    for (int i = 0; i < 30; i++) begin
      case ($urandom % 4)
        0: b = 32'd0;
        1: b = $urandom % 16;
        default: b = $urandom;
      endcase
      issue(1'($urandom), $urandom, b);
    end

    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative unsigned multiply/divide sequencer for the MIPS EX stage. It borrows the shared 32-bit ALU (ctl encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT) for 32 cycles to implement MULTU and DIVU. It produces the HI and LO results. While the sequencer owns the ALU, the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/ALU width; ITER = WIDTH iterations per operation
CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  operation request; accepted only in IDLE
op  input  1  0 = MULTU, 1 = DIVU
opa  input  WIDTH  multiplicand / dividend
opb  input  WIDTH  multiplier / divisor
alu_result  input  WIDTH  shared ALU DATAOUT bus
alu_cout  input  1  shared ALU carry out of MSB slice
alu_a  output  WIDTH  ALU A operand while owned
alu_b  output  WIDTH  ALU B operand while owned
alu_ctl  output  3  ALU control while owned
alu_own  output  1  1 = ALU input mux selects this block
busy  output  1  state != IDLE; pipeline stall request
done  output  1  one-cycle completion pulse
div_by_zero  output  1  valid with done; sticky until next accepted start
hi  output  WIDTH  HI register (product high / remainder)
lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE, cnt=0, hi=lo=0, busy=done=div_by_zero=alu_own=0, alu_a=alu_b=0, alu_ctl=000. The operation in progress is discarded.
- States: IDLE, RUN, FIN.
- IDLE: start=1 -> latch op and opb into internal op_r and opnd_r, cnt=0, div_by_zero=0.
  - MULTU: hi=0, lo=opa.
  - DIVU: hi=0, lo=opa.
  - If op=1 and opb=0: go to FIN with div_by_zero=1, hi=opa, lo=all-ones. The ALU is not taken.
  - Otherwise go to RUN.
- RUN: alu_own=1. There is one iteration per cycle. cnt increments each cycle; leave for FIN after the iteration with cnt=ITER-1. alu_* are combinational from the registers; result is captured at the clock edge.
  - MULTU iteration:
    - Drive alu_ctl=010, alu_a=hi, alu_b = lo[0] ? opnd_r : 0.
    - Update {hi,lo} <= {alu_cout, alu_result, lo} >> 1, i.e. hi={alu_cout,alu_result[W-1:1]}, lo={alu_result[0],lo[W-1:1]}.
  - DIVU iteration (restoring):
    - Define sh={hi[W-2:0],lo[W-1]}.
    - Drive alu_ctl=110, alu_a=sh, alu_b=opnd_r.
    - If hi[W-1]=1 or alu_cout=1 (no borrow): hi=alu_result, lo={lo[W-2:0],1}.
    - Else: hi=sh, lo={lo[W-2:0],0}.
- FIN: done=1 for exactly this cycle; busy=1, alu_own=0. Next cycle -> IDLE. hi/lo hold until the next accepted start or reset.
- Latency:
  - start accepted at edge E0; RUN occupies cycles 1..32; done is high in cycle 33.
  - Divide-by-zero: done is high in cycle 1.
- start while busy is ignored; no queueing; no error flag.
- start in FIN is ignored. start in the first IDLE cycle after FIN is accepted.
- Outside RUN: alu_own=0, alu_a=alu_b=0, alu_ctl=000.
- op and opa/opb are sampled only at acceptance. Later changes have no effect.
- Arithmetic: all unsigned, results modulo 2^64 product split hi:lo. The ALU carry is used as the 33rd product bit and as the not-borrow flag.

Test Plan:
- Reset, then MULTU 7 x 6 -> busy in cycles 1..33, alu_own in 1..32, done in cycle 33 only; hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; exercises alu_cout capture every iteration.
- DIVU 100 / 7 -> lo=14, hi=2. DIVU 0xFFFFFFFF / 0x80000001 -> lo=1, hi=0x7FFFFFFE; covers the hi[W-1]=1 forced-subtract path.
- DIVU 5 / 0 -> done in cycle 1, div_by_zero=1, hi=5, lo=0xFFFFFFFF, alu_own never asserted. Next DIVU 9/3 clears div_by_zero -> lo=3, hi=0.
- Pulse start with new operands in cycles 5 and 33 of a MULTU 3x4 -> ignored; result lo=12; back-to-back start in the cycle after done is accepted.
- Assert rst in cycle 10 of a DIVU -> next cycle IDLE, hi=lo=0, busy=done=0. A subsequent MULTU 2x3 yields lo=6.
